// File: rtl/button_click_decoder_if.sv
// Mouse-side inputs, game-FSM enables and decoded command/highlight outputs of
// the button click decoder, bundled so the decoder and its driver share one port.
interface button_click_decoder_if;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        left;
  logic        deal_en;
  logic        hit_en;
  logic        stand_en;
  logic        deal_cmd;
  logic        hit_cmd;
  logic        stand_cmd;
  logic [1:0]  hover;
  logic [1:0]  armed;

  modport master (
    output xpos, ypos, left, deal_en, hit_en, stand_en,
    input  deal_cmd, hit_cmd, stand_cmd, hover, armed
  );

  modport slave (
    input  xpos, ypos, left, deal_en, hit_en, stand_en,
    output deal_cmd, hit_cmd, stand_cmd, hover, armed
  );
endinterface

// File: rtl/button_click_decoder.sv
// Decodes pointer position and left-button edges into DEAL/HIT/STAND pulses plus hover/armed.
// Latency: cmd 2 edges after release sample, hover 3 cycles from xpos/ypos; no backpressure.
module button_click_decoder #(
  parameter int BTN1_X          = 100,
  parameter int BTN2_X          = 300,
  parameter int BTN3_X          = 500,
  parameter int BTN_Y           = 400,
  parameter int BTN_W           = 100,
  parameter int BTN_H           = 50,
  parameter int COOLDOWN_CYCLES = 650_000
) (
  input  logic                  clk,
  input  logic                  rst,
  button_click_decoder_if.slave bus
);

  localparam int CNT_W = $clog2(COOLDOWN_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);

  localparam logic [12:0] X1  = 13'(BTN1_X);
  localparam logic [12:0] X2  = 13'(BTN2_X);
  localparam logic [12:0] X3  = 13'(BTN3_X);
  localparam logic [12:0] Y0  = 13'(BTN_Y);
  localparam logic [12:0] W13 = 13'(BTN_W);
  localparam logic [12:0] H13 = 13'(BTN_H);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  // Two-stage input pipeline; l3 is left one cycle behind s2 for edge detection.
  logic [11:0] s1_x, s1_y, s2_x, s2_y;
  logic        s1_left, s2_left, l3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_x    <= '0;
      s1_y    <= '0;
      s1_left <= 1'b0;
      s2_x    <= '0;
      s2_y    <= '0;
      s2_left <= 1'b0;
      l3      <= 1'b0;
    end else begin
      s1_x    <= bus.xpos;
      s1_y    <= bus.ypos;
      s1_left <= bus.left;
      s2_x    <= s1_x;
      s2_y    <= s1_y;
      s2_left <= s1_left;
      l3      <= s2_left;
    end
  end

  logic rise;
  logic fall;

  assign rise = s2_left & ~l3;
  assign fall = ~s2_left & l3;

  // Widened to 13 bits so edge + width cannot wrap for 12-bit button origins.
  logic [12:0] x13;
  logic [12:0] y13;

  assign x13 = {1'b0, s2_x};
  assign y13 = {1'b0, s2_y};

  function automatic logic in_btn(input logic [12:0] bx, input logic [12:0] x,
                                  input logic [12:0] y);
    return (x >= bx) && (x < bx + W13) && (y >= Y0) && (y < Y0 + H13);
  endfunction

  logic [1:0] hit_id;

  always_comb begin
    hit_id = 2'd0;
    if (bus.deal_en && in_btn(X1, x13, y13)) begin
      hit_id = 2'd1;
    end else if (bus.hit_en && in_btn(X2, x13, y13)) begin
      hit_id = 2'd2;
    end else if (bus.stand_en && in_btn(X3, x13, y13)) begin
      hit_id = 2'd3;
    end
  end

  state_t           state;
  logic [1:0]       latched;
  logic [CNT_W-1:0] cnt;
  logic             latched_en;
  logic             deal_cmd;
  logic             hit_cmd;
  logic             stand_cmd;
  logic [1:0]       hover;
  logic [1:0]       armed;

  always_comb begin
    latched_en = 1'b0;
    case (latched)
      2'd1:    latched_en = bus.deal_en;
      2'd2:    latched_en = bus.hit_en;
      2'd3:    latched_en = bus.stand_en;
      default: latched_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      latched   <= 2'd0;
      cnt       <= '0;
      deal_cmd  <= 1'b0;
      hit_cmd   <= 1'b0;
      stand_cmd <= 1'b0;
      hover     <= 2'd0;
      armed     <= 2'd0;
    end else begin
      hover     <= hit_id;
      deal_cmd  <= 1'b0;
      hit_cmd   <= 1'b0;
      stand_cmd <= 1'b0;
      case (state)
        IDLE: begin
          if (rise && (hit_id != 2'd0)) begin
            latched <= hit_id;
            armed   <= hit_id;
            state   <= ARMED;
          end
        end
        ARMED: begin
          // A disabled button never fires, even when the release lands the same cycle.
          if (!latched_en) begin
            armed <= 2'd0;
            state <= IDLE;
          end else if (fall) begin
            armed <= 2'd0;
            if (hit_id == latched) begin
              deal_cmd  <= (latched == 2'd1);
              hit_cmd   <= (latched == 2'd2);
              stand_cmd <= (latched == 2'd3);
              cnt       <= CNT_LOAD;
              state     <= COOLDOWN;
            end else begin
              state <= IDLE;
            end
          end
        end
        COOLDOWN: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          armed <= 2'd0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.deal_cmd  = deal_cmd;
  assign bus.hit_cmd   = hit_cmd;
  assign bus.stand_cmd = stand_cmd;
  assign bus.hover     = hover;
  assign bus.armed     = armed;

endmodule

// File: doc/button_click_decoder.md
# button_click_decoder

Input-side counterpart of the button renderer: decodes mouse position and left-button activity into one-cycle DEAL / HIT / STAND command pulses for the blackjack game controller. It sits between the mouse controller, which supplies xpos/ypos/left in the pixel clock domain, and the game FSM, which supplies per-button enables and consumes the command pulses. It also exports hover and armed indications so the renderer can highlight buttons.

## Interface
- BTN1_X, 100: DEAL left edge (px)
- BTN2_X, 300: HIT left edge
- BTN3_X, 500: STAND left edge
- BTN_Y, 400: top edge, all buttons
- BTN_W, 100: button width
- BTN_H, 50: button height
- COOLDOWN_CYCLES, 650_000: post-command lockout length (~10 ms at 65 MHz); must be >= 1
- clk  in  1  pixel clock, sole clock
- rst  in  1  synchronous reset, active-high
- xpos  in  12  pointer x
- ypos  in  12  pointer y
- left  in  1  left mouse button level, 1 = pressed
- deal_en, hit_en, stand_en  in  1 each  button enables from game FSM
- deal_cmd, hit_cmd, stand_cmd  out  1 each  one-cycle command pulses, registered
- hover  out  2  0 none, 1 DEAL, 2 HIT, 3 STAND; enabled buttons only; registered
- armed  out  2  button currently held, same encoding; registered

## Operation
- Input pipeline: left, xpos, ypos pass through two register stages (s1, s2); third register l3 holds the previous s2 value of left. rise = s2 & ~l3; fall = ~s2 & l3.
- Hit test on s2 coordinates, unsigned, 13-bit widened: inside button n iff x >= BTNn_X && x < BTNn_X+BTN_W && y >= BTN_Y && y < BTN_Y+BTN_H && n_en. Lower bound inclusive, upper exclusive. On overlap, priority DEAL > HIT > STAND. Result hit_id (0..3).
- FSM states:
  - IDLE: on rise with hit_id != 0, latch id, go to ARMED. Rise with hit_id == 0 is ignored; no arming until the next rise.
  - ARMED: on fall with hit_id == latched id, pulse the matching cmd and go to COOLDOWN, loading the counter with COOLDOWN_CYCLES-1. On fall elsewhere, go to IDLE with no pulse. If the latched button's enable deasserts, go to IDLE with no pulse. An enable drop in the same cycle as fall gives no pulse.
  - COOLDOWN: decrement each cycle; at 0 go to IDLE. All rise/fall events are ignored. A press begun during cooldown never arms, even if still held at exit.
- Pointer leaving and re-entering the armed button while held is allowed; only position at fall matters.
- armed = latched id in ARMED, else 0. hover = hit_id every cycle, independent of FSM state.
- At most one cmd high in any cycle; each accepted click yields exactly one pulse.

## Timing
- Reset: all pipeline registers 0, FSM IDLE, counter 0, deal_cmd/hit_cmd/stand_cmd 0, hover 0, armed 0. Reset mid-ARMED or mid-COOLDOWN aborts with no pulse. A left held through reset deassertion reads as s2=1, l3=0 → rise, and arms if pointer is over an enabled button.
- left change sampled at edge k: rise/fall visible after edge k+1; FSM state, armed, and cmd update at edge k+2. The cmd pulse is high for exactly the one cycle following edge k+2.
- hover follows xpos/ypos with 3-cycle latency (s1, s2, output register); enables are sampled directly, with 1-cycle latency.
- Cooldown: the FSM stays in COOLDOWN for exactly COOLDOWN_CYCLES cycles after the pulse edge, then returns to IDLE.

## Test plan
- Press and release at (150,420), deal_en=1 → deal_cmd high exactly 1 cycle, 2 edges after the release sample; armed=1 during hold; hit_cmd and stand_cmd stay 0.
- Press at (350,425) on HIT, drag to (550,425), release → no cmd; armed returns 0 after fall. Press outside at (50,50), drag onto HIT, release → no cmd.
- Boundaries with BTN defaults, hit_en=1: x=299/400 → hover 0; x=300/399 → hover 2; y=399/450 → 0; y=400/449 → 2.
- COOLDOWN_CYCLES=8: STAND click, then second full click starting 3 cycles after stand_cmd → no second pulse. Same click started after 8 cycles → second stand_cmd.
- Arm DEAL, drop deal_en before release → no deal_cmd, armed=0 one cycle after drop. Arm HIT, assert rst while held → all outputs 0, no hit_cmd after release.
- Hover with stand_en=0 at (520,410) → hover 0; a full click there produces no cmd.
